// File: rtl/sqrt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_iter
//  Brief    : Iterative integer square root, restoring digit-by-digit method,
//             one root bit per clock (MSB first), valid/ready handshakes on
//             both sides. ROUND selects floor or round-to-nearest root.
//             Optional macro SQRT_REM_EN adds the out_rem port (floor
//             remainder).
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_iter #(
  parameter int WIDTH = 32,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_value,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]   out_rem
`endif
);

  localparam int                   c_half     = WIDTH / 2;
  localparam int                   c_cnt_w    = $clog2(c_half) + 1;
  localparam logic [c_cnt_w-1:0]   c_last     = c_cnt_w'(c_half - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_half-1:0]    c_root_max = '1;
  localparam logic [c_half-1:0]    c_root_one = c_half'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [WIDTH-1:0]    r_x;        // radicand, consumed two bits per step
  logic [c_half+1:0]   r_rem;      // partial remainder
  logic [c_half-1:0]   r_q;        // partial root
  logic [c_cnt_w-1:0]  r_cnt;      // iteration index within CALC

  logic                w_accept;
  logic                w_last;
  logic [c_half+1:0]   w_rem_sh;
  logic [c_half+1:0]   w_trial;
  logic                w_ge;
  logic [c_half+1:0]   w_rem_nx;
  logic [c_half-1:0]   w_q_nx;
  logic [c_half-1:0]   w_root_fin;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == c_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state and handshake outputs; a DONE that is drained while a new
  // radicand waits goes straight back to CALC with no idle bubble.
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = CALC;
      end
      CALC: begin
        if (w_last) w_state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nx = in_valid ? CALC : IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // One restoring step: bring down the next two radicand bits, try to
  // subtract (4*q + 1), and shift the resulting root bit in. The remainder
  // never exceeds 2*q, so WIDTH/2+2 bits hold every intermediate value.
  always_comb begin
    w_rem_sh   = (r_rem << 2) | {{c_half{1'b0}}, r_x[WIDTH-1 -: 2]};
    w_trial    = {r_q, 2'b01};
    w_ge       = (w_rem_sh >= w_trial);
    w_rem_nx   = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    w_q_nx     = (r_q << 1) | {{(c_half-1){1'b0}}, w_ge};
    w_root_fin = w_q_nx;
    // sqrt(x) >= q + 0.5 exactly when the floor remainder exceeds q.
    if (ROUND != 0) begin
      if ((w_rem_nx > {2'b00, w_q_nx}) && (w_q_nx != c_root_max))
        w_root_fin = w_q_nx + c_root_one;
    end
  end

  // Iteration registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      out_root <= '0;
`ifdef SQRT_REM_EN
      out_rem  <= '0;
`endif
    end else if (w_accept) begin
      r_x   <= in_value;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_x   <= r_x << 2;
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt + c_cnt_one;
      if (w_last) begin
        out_root <= w_root_fin;
`ifdef SQRT_REM_EN
        out_rem  <= w_rem_nx[c_half:0];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_iter
//  Brief    : Self-checking bench for sqrt_iter. Two 32-bit instances (floor
//             and rounding) share one stimulus stream; two 8-bit instances
//             share another. Expected roots come from a real-valued sqrt model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_iter;

  logic clk;
  logic rst_n;

  // 32-bit group
  logic        a_vld, a_ordy;
  logic [31:0] a_val;
  logic        a0_ir, a0_ov, a1_ir, a1_ov;
  logic [15:0] a0_root, a1_root;
  // 8-bit group
  logic        b_vld, b_ordy;
  logic [7:0]  b_val;
  logic        b0_ir, b0_ov, b1_ir, b1_ov;
  logic [3:0]  b0_root, b1_root;
`ifdef SQRT_REM_EN
  logic [16:0] a0_rem, a1_rem;
  logic [4:0]  b0_rem, b1_rem;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sqrt_iter #(.WIDTH(32), .ROUND(0)) u_a0 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_value(a_val),
    .in_ready(a0_ir), .out_valid(a0_ov), .out_ready(a_ordy), .out_root(a0_root)
`ifdef SQRT_REM_EN
    , .out_rem(a0_rem)
`endif
  );
  sqrt_iter #(.WIDTH(32), .ROUND(1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_value(a_val),
    .in_ready(a1_ir), .out_valid(a1_ov), .out_ready(a_ordy), .out_root(a1_root)
`ifdef SQRT_REM_EN
    , .out_rem(a1_rem)
`endif
  );
  sqrt_iter #(.WIDTH(8), .ROUND(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_value(b_val),
    .in_ready(b0_ir), .out_valid(b0_ov), .out_ready(b_ordy), .out_root(b0_root)
`ifdef SQRT_REM_EN
    , .out_rem(b0_rem)
`endif
  );
  sqrt_iter #(.WIDTH(8), .ROUND(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_value(b_val),
    .in_ready(b1_ir), .out_valid(b1_ov), .out_ready(b_ordy), .out_root(b1_root)
`ifdef SQRT_REM_EN
    , .out_rem(b1_rem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: floor sqrt from real arithmetic, nudged to the exact integer.
  function automatic longint ref_floor(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint ref_round(input longint x, input int w);
    longint r;
    r = ref_floor(x);
    if (((x - r * r) > r) && (r < ((longint'(1) << (w / 2)) - 1))) r++;
    return r;
  endfunction

  function automatic logic ready0(input int g);
    return (g == 0) ? a0_ir : b0_ir;
  endfunction
  function automatic logic ready1(input int g);
    return (g == 0) ? a1_ir : b1_ir;
  endfunction
  function automatic logic valid0(input int g);
    return (g == 0) ? a0_ov : b0_ov;
  endfunction
  function automatic logic valid1(input int g);
    return (g == 0) ? a1_ov : b1_ov;
  endfunction
  function automatic longint root0(input int g);
    return (g == 0) ? longint'(a0_root) : longint'(b0_root);
  endfunction
  function automatic longint root1(input int g);
    return (g == 0) ? longint'(a1_root) : longint'(b1_root);
  endfunction
`ifdef SQRT_REM_EN
  function automatic longint rem0(input int g);
    return (g == 0) ? longint'(a0_rem) : longint'(b0_rem);
  endfunction
  function automatic longint rem1(input int g);
    return (g == 0) ? longint'(a1_rem) : longint'(b1_rem);
  endfunction
`endif

  // Hold results back and throw junk at the (ignored) input side.
  task automatic noise(input int g);
    if (g == 0) begin
      a_ordy = 1'b0; a_vld = 1'($urandom_range(0, 1)); a_val = $urandom;
    end else begin
      b_ordy = 1'b0; b_vld = 1'($urandom_range(0, 1)); b_val = 8'($urandom);
    end
  endtask

  // Offer x (draining any pending result on the same edge), measure latency,
  // check both roots, then hold the result for `hold` cycles.
  task automatic txn(input int g, input longint x, input longint exp_f,
                     input longint exp_r, input int hold, input int lat_exp);
    int lat;
    if (g == 0) begin a_ordy = 1'b1; a_vld = 1'b1; a_val = x[31:0]; end
    else        begin b_ordy = 1'b1; b_vld = 1'b1; b_val = x[7:0];  end
    #1;
    check_eq("accept_ready0", longint'(ready0(g)), 1);
    check_eq("accept_ready1", longint'(ready1(g)), 1);
    @(posedge clk); #1;
    noise(g);
    lat = 0;
    while (!valid0(g) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      noise(g);
    end
    check_eq("latency", lat, lat_exp);
    check_eq("valid_round", longint'(valid1(g)), 1);
    check_eq("root_floor", root0(g), exp_f);
    check_eq("root_round", root1(g), exp_r);
`ifdef SQRT_REM_EN
    check_eq("rem_floor", rem0(g), x - exp_f * exp_f);
    check_eq("rem_round", rem1(g), x - exp_f * exp_f);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      noise(g);
      check_eq("hold_valid", longint'(valid0(g)), 1);
      check_eq("hold_ready", longint'(ready0(g)), 0);
      check_eq("hold_root_floor", root0(g), exp_f);
      check_eq("hold_root_round", root1(g), exp_r);
    end
  endtask

  task automatic go_idle(input int g);
    if (g == 0) begin a_ordy = 1'b1; a_vld = 1'b0; end
    else        begin b_ordy = 1'b1; b_vld = 1'b0; end
    @(posedge clk); #1;
    check_eq("idle_valid", longint'(valid0(g)), 0);
    check_eq("idle_ready", longint'(ready0(g)), 1);
  endtask

  longint dx [9] = '{0, 1, 2, 3, 4, 12, 13, 30, 64'hFFFF_FFFF};
  longint df [9] = '{0, 1, 1, 1, 2, 3, 3, 5, 65535};
  longint dr [9] = '{0, 1, 1, 2, 2, 3, 4, 5, 65535};

  initial begin
    longint x;
    logic   seen_valid;
    rst_n = 1'b0;
    a_vld = 1'b0; a_ordy = 1'b0; a_val = '0;
    b_vld = 1'b0; b_ordy = 1'b0; b_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_a", longint'(a0_ov), 0);
    check_eq("rst_root_a0", longint'(a0_root), 0);
    check_eq("rst_root_a1", longint'(a1_root), 0);
    check_eq("rst_valid_b", longint'(b0_ov), 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", longint'(a0_ir), 1);

    // Directed values, including zero and all-ones.
    for (int i = 0; i < 9; i++) begin
      txn(0, dx[i], df[i], dr[i], i % 3, 16);
      if (i % 2 == 1) go_idle(0);
    end

    // Long back-pressure then zero-bubble turnaround.
    txn(0, 144, 12, 12, 5, 16);
    txn(0, 169, 13, 13, 1, 16);
    go_idle(0);

    // Random 32-bit radicands.
    for (int i = 0; i < 20; i++) begin
      x = longint'($urandom);
      txn(0, x, ref_floor(x), ref_round(x, 32), int'($urandom_range(0, 2)), 16);
      if ($urandom_range(0, 1) == 1) go_idle(0);
    end
    go_idle(0);

    // Reset in the middle of a computation.
    a_ordy = 1'b1; a_vld = 1'b1; a_val = 32'd1000000;
    @(posedge clk); #1;
    a_vld = 1'b0; a_ordy = 1'b0;
    seen_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | a0_ov;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", longint'(a0_ov), 0);
    check_eq("abort_root", longint'(a0_root), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready", longint'(a0_ir), 1);
    repeat (20) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | a0_ov;
    end
    check_eq("abort_no_result", longint'(seen_valid), 0);
    txn(0, 81, 9, 9, 0, 16);
    go_idle(0);

    // Exhaustive 8-bit sweep with random back-pressure.
    for (int v = 0; v < 256; v++) begin
      x = longint'(v);
      txn(1, x, ref_floor(x), ref_round(x, 8), int'($urandom_range(0, 3)), 4);
      if ($urandom_range(0, 3) == 0) go_idle(1);
    end
    go_idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
